regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 84 ++++++++
 tb/tb_regfile_mp.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-ported register file with two write ports, NRD combinational read ports,
// optional write-to-read forwarding and a post-reset zeroing sweep that gates all traffic.
module regfile_mp #(
  parameter int  XLEN     = 32,
  parameter int  NREGS    = 32,
  parameter int  NRD      = 2,
  parameter int  BYPASS   = 1,
  parameter int  ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     r_sel,
  output logic [NRD*XLEN-1:0]   r_data,
  input  logic                  w_en_0,
  input  logic                  w_en_1,
  input  logic [AW-1:0]         w_sel_0,
  input  logic [AW-1:0]         w_sel_1,
  input  logic [XLEN-1:0]       w_data_0,
  input  logic [XLEN-1:0]       w_data_1,
  input  logic [AW-1:0]         dbg_reg_sel,
  output logic [XLEN-1:0]       dbg_reg_data,
  output logic                  rdy,
  output logic [AW-1:0]         clr_cnt
);

  typedef enum logic {SWEEP = 1'b0, READY = 1'b1} state_e;

  state_e            state_q;
  logic [AW-1:0]     clr_cnt_q;
  logic [AW-1:0]     clr_cnt_d;
  logic [XLEN-1:0]   regs_q [NREGS];
  logic              wr0_act;
  logic              wr1_act;

  assign clr_cnt_d = clr_cnt_q + AW'(1);

  // A write is live only in READY, outside reset, and not aimed at a hardwired x0.
  assign wr0_act = (state_q == READY) && !rst && w_en_0 &&
                   !((ZERO_REG != 0) && (w_sel_0 == '0));
  assign wr1_act = (state_q == READY) && !rst && w_en_1 &&
                   !((ZERO_REG != 0) && (w_sel_1 == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SWEEP;
      clr_cnt_q <= '0;
    end else if (state_q == SWEEP) begin
      clr_cnt_q <= clr_cnt_d;
      if (clr_cnt_q == AW'(NREGS - 1)) state_q <= READY;
    end
  end

  // Port 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (state_q == SWEEP && !rst) regs_q[clr_cnt_q] <= '0;
    if (wr0_act) regs_q[w_sel_0] <= w_data_0;
    if (wr1_act) regs_q[w_sel_1] <= w_data_1;
  end

  always_comb begin
    r_data = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0]   sel;
      logic [XLEN-1:0] val;
      sel = r_sel[i*AW +: AW];
      val = regs_q[sel];
      if ((BYPASS != 0) && wr0_act && (w_sel_0 == sel)) val = w_data_0;
      if ((BYPASS != 0) && wr1_act && (w_sel_1 == sel)) val = w_data_1;
      if ((state_q != READY) || ((ZERO_REG != 0) && (sel == '0))) val = '0;
      r_data[i*XLEN +: XLEN] = val;
    end
  end

  always_comb begin
    dbg_reg_data = regs_q[dbg_reg_sel];
    if ((state_q != READY) || ((ZERO_REG != 0) && (dbg_reg_sel == '0)))
      dbg_reg_data = '0;
  end

  assign rdy     = (state_q == READY);
  assign clr_cnt = clr_cnt_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default (bypass), no-bypass and small (8x16, 3 read ports, x0 writable)
// instances driven per cycle and compared against array-based reference models.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instances A (BYPASS=1) and B (BYPASS=0) share all inputs.
  logic [9:0]  a_rsel;
  logic [63:0] a_rdata, b_rdata;
  logic        a_wen0, a_wen1;
  logic [4:0]  a_ws0, a_ws1, a_dsel;
  logic [31:0] a_wd0, a_wd1, a_dbg, b_dbg;
  logic        a_rdy, b_rdy;
  logic [4:0]  a_cnt, b_cnt;

  logic [8:0]  c_rsel;
  logic [47:0] c_rdata;
  logic        c_wen0, c_wen1;
  logic [2:0]  c_ws0, c_ws1, c_dsel;
  logic [15:0] c_wd0, c_wd1, c_dbg;
  logic        c_rdy;
  logic [2:0]  c_cnt;

  regfile_mp #(.BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .r_sel(a_rsel), .r_data(a_rdata),
    .w_en_0(a_wen0), .w_en_1(a_wen1), .w_sel_0(a_ws0), .w_sel_1(a_ws1),
    .w_data_0(a_wd0), .w_data_1(a_wd1), .dbg_reg_sel(a_dsel),
    .dbg_reg_data(a_dbg), .rdy(a_rdy), .clr_cnt(a_cnt));

  regfile_mp #(.BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .r_sel(a_rsel), .r_data(b_rdata),
    .w_en_0(a_wen0), .w_en_1(a_wen1), .w_sel_0(a_ws0), .w_sel_1(a_ws1),
    .w_data_0(a_wd0), .w_data_1(a_wd1), .dbg_reg_sel(a_dsel),
    .dbg_reg_data(b_dbg), .rdy(b_rdy), .clr_cnt(b_cnt));

  regfile_mp #(.XLEN(16), .NREGS(8), .NRD(3), .ZERO_REG(0)) u_c (
    .clk(clk), .rst(rst), .r_sel(c_rsel), .r_data(c_rdata),
    .w_en_0(c_wen0), .w_en_1(c_wen1), .w_sel_0(c_ws0), .w_sel_1(c_ws1),
    .w_data_0(c_wd0), .w_data_1(c_wd1), .dbg_reg_sel(c_dsel),
    .dbg_reg_data(c_dbg), .rdy(c_rdy), .clr_cnt(c_cnt));

  int ntests = 0;
  int nfail  = 0;

  // Reference state: contents as seen once ready, readiness and sweep position.
  logic [31:0] ma [32];
  bit          mrdy_a;
  int          mcnt_a;
  logic [15:0] mc [8];
  bit          mrdy_c;
  int          mcnt_c;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_a(input int a, input bit byp);
    if (!mrdy_a || a == 0) return 32'h0;
    if (byp && a_wen1 && a_ws1 != 0 && int'(a_ws1) == a) return a_wd1;
    if (byp && a_wen0 && a_ws0 != 0 && int'(a_ws0) == a) return a_wd0;
    return ma[a];
  endfunction

  function automatic logic [15:0] exp_c(input int a, input bit byp);
    if (!mrdy_c) return 16'h0;
    if (byp && c_wen1 && int'(c_ws1) == a) return c_wd1;
    if (byp && c_wen0 && int'(c_ws0) == a) return c_wd0;
    return mc[a];
  endfunction

  task automatic update_models();
    if (rst) begin
      mrdy_a = 0; mcnt_a = 0; mrdy_c = 0; mcnt_c = 0;
    end else begin
      if (!mrdy_a) begin
        mcnt_a++;
        if (mcnt_a == 32) begin
          mrdy_a = 1; mcnt_a = 0;
          foreach (ma[k]) ma[k] = 32'h0;
        end
      end else begin
        if (a_wen0 && a_ws0 != 0) ma[a_ws0] = a_wd0;
        if (a_wen1 && a_ws1 != 0) ma[a_ws1] = a_wd1;
      end
      if (!mrdy_c) begin
        mcnt_c++;
        if (mcnt_c == 8) begin
          mrdy_c = 1; mcnt_c = 0;
          foreach (mc[k]) mc[k] = 16'h0;
        end
      end else begin
        if (c_wen0) mc[c_ws0] = c_wd0;
        if (c_wen1) mc[c_ws1] = c_wd1;
      end
    end
  endtask

  // Outputs are compared mid-cycle against the model; the model then steps on the edge.
  task automatic do_cycle();
    @(negedge clk);
    check("a_rdy", a_rdy, mrdy_a);
    check("b_rdy", b_rdy, mrdy_a);
    check("c_rdy", c_rdy, mrdy_c);
    check("a_clr_cnt", a_cnt, mcnt_a);
    check("b_clr_cnt", b_cnt, mcnt_a);
    check("c_clr_cnt", c_cnt, mcnt_c);
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("a_rdata%0d", p), a_rdata[p*32 +: 32], exp_a(a_rsel[p*5 +: 5], 1'b1));
        check($sformatf("b_rdata%0d", p), b_rdata[p*32 +: 32], exp_a(a_rsel[p*5 +: 5], 1'b0));
      end
      check("a_dbg", a_dbg, exp_a(a_dsel, 1'b0));
      check("b_dbg", b_dbg, exp_a(a_dsel, 1'b0));
      for (int p = 0; p < 3; p++)
        check($sformatf("c_rdata%0d", p), c_rdata[p*16 +: 16], exp_c(c_rsel[p*3 +: 3], 1'b1));
      check("c_dbg", c_dbg, exp_c(c_dsel, 1'b0));
    end
    @(posedge clk);
    update_models();
    #1;
  endtask

  task automatic idle();
    a_wen0 = 0; a_wen1 = 0; c_wen0 = 0; c_wen1 = 0;
  endtask

  task automatic rand_inputs();
    a_wen0 = 1'($urandom_range(0, 1)); a_wen1 = 1'($urandom_range(0, 1));
    a_ws0  = 5'($urandom_range(0, 11)); a_ws1 = 5'($urandom_range(0, 11));
    a_wd0  = $urandom; a_wd1 = $urandom;
    a_rsel = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
    a_dsel = 5'($urandom_range(0, 11));
    c_wen0 = 1'($urandom_range(0, 1)); c_wen1 = 1'($urandom_range(0, 1));
    c_ws0  = 3'($urandom); c_ws1 = 3'($urandom);
    c_wd0  = 16'($urandom); c_wd1 = 16'($urandom);
    c_rsel = 9'($urandom);
    c_dsel = 3'($urandom);
  endtask

  initial begin
    foreach (ma[k]) ma[k] = 32'hX;
    foreach (mc[k]) mc[k] = 16'hX;
    mrdy_a = 0; mcnt_a = 0; mrdy_c = 0; mcnt_c = 0;
    rst = 1;
    rand_inputs();
    #1;

    // Reset for two cycles, then the sweep runs with random (ignored) writes.
    do_cycle();
    do_cycle();
    rst = 0;
    for (int n = 0; n < 34; n++) begin
      rand_inputs();
      do_cycle();
    end

    // Every register reads zero right after the sweep.
    idle();
    for (int r = 0; r < 32; r++) begin
      a_rsel = {5'(31 - r), 5'(r)};
      a_dsel = 5'(r);
      c_rsel = {3'(r), 3'(r + 1), 3'(r + 2)};
      c_dsel = 3'(r);
      do_cycle();
    end

    // Write x5, read it back next cycle; write to x0 is dropped.
    idle(); a_wen0 = 1; a_ws0 = 5'd5; a_wd0 = 32'hDEADBEEF; a_rsel = {5'd1, 5'd2};
    do_cycle();
    idle(); a_rsel = {5'd0, 5'd5}; a_dsel = 5'd5;
    do_cycle();
    idle(); a_wen0 = 1; a_ws0 = 5'd0; a_wd0 = 32'h1234;
    c_wen0 = 1; c_ws0 = 3'd0; c_wd0 = 16'hBEEF;
    do_cycle();
    idle(); a_rsel = {5'd0, 5'd0}; a_dsel = 5'd0; c_rsel = {3'd0, 3'd1, 3'd0}; c_dsel = 3'd0;
    do_cycle();

    // Collision on x7 (port 1 wins), then distinct x7/x8.
    idle(); a_wen0 = 1; a_wen1 = 1; a_ws0 = 5'd7; a_ws1 = 5'd7;
    a_wd0 = 32'h11111111; a_wd1 = 32'h22222222;
    do_cycle();
    idle(); a_rsel = {5'd7, 5'd7}; a_dsel = 5'd7;
    do_cycle();
    idle(); a_wen0 = 1; a_wen1 = 1; a_ws0 = 5'd7; a_ws1 = 5'd8;
    a_wd0 = 32'h33333333; a_wd1 = 32'h44444444;
    do_cycle();
    idle(); a_rsel = {5'd8, 5'd7}; a_dsel = 5'd8;
    do_cycle();

    // Forwarding: seed x9, then write and read it in the same cycle.
    idle(); a_wen0 = 1; a_ws0 = 5'd9; a_wd0 = 32'h0BADF00D;
    do_cycle();
    idle(); a_wen1 = 1; a_ws1 = 5'd9; a_wd1 = 32'hA5A5A5A5;
    a_rsel = {5'd9, 5'd3}; a_dsel = 5'd9;
    do_cycle();
    idle(); a_rsel = {5'd9, 5'd9}; a_dsel = 5'd9;
    do_cycle();

    for (int n = 0; n < 300; n++) begin
      rand_inputs();
      do_cycle();
    end

    // Reset while ready, then reset again mid-sweep at index 17.
    rst = 1; rand_inputs();
    do_cycle();
    rst = 0;
    for (int n = 0; n < 17; n++) begin
      rand_inputs();
      do_cycle();
    end
    check("a_cnt_at_17", a_cnt, 17);
    rst = 1; rand_inputs();
    do_cycle();
    rst = 0;
    for (int n = 0; n < 33; n++) begin
      rand_inputs();
      do_cycle();
    end
    idle();
    for (int r = 0; r < 32; r++) begin
      a_rsel = {5'(r), 5'(r)};
      a_dsel = 5'(r);
      do_cycle();
    end

    for (int n = 0; n < 200; n++) begin
      rand_inputs();
      do_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
